// File: rtl/noc_params.sv
// noc_params: shared router types, port indices and the switch-allocator state enum.
package noc_params;
    localparam int PORT_NUM  = 9;
    localparam int PORT_SIZE = $clog2(PORT_NUM);

    typedef logic [PORT_SIZE-1:0] port_t;
    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
    typedef enum logic {SA_IDLE, SA_LOCKED} sa_state_t;

    localparam port_t DLA0  = 4'd0;
    localparam port_t DLA1  = 4'd1;
    localparam port_t DLA2  = 4'd2;
    localparam port_t DLA3  = 4'd3;
    localparam port_t SKIP  = 4'd4;
    localparam port_t NORTH = 4'd5;
    localparam port_t SOUTH = 4'd6;
    localparam port_t WEST  = 4'd7;
    localparam port_t EAST  = 4'd8;
    localparam port_t PORT_LAST = port_t'(PORT_NUM - 1);

    function automatic port_t next_port(input port_t p);
        return (p == PORT_LAST) ? '0 : p + 1'b1;
    endfunction
endpackage

// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: combinational round-robin pick of the first request at or after i_ptr.
module noc_rr_arbiter
    import noc_params::*;
(
    input  logic [PORT_NUM-1:0] i_req,
    input  port_t               i_ptr,
    output logic [PORT_NUM-1:0] o_gnt,
    output port_t               o_idx,
    output logic                o_any
);
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        // Scan farthest offset first so the closest request to the pointer wins last.
        for (int k = PORT_NUM - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % PORT_NUM]) begin
                o_idx = port_t'((int'(i_ptr) + k) % PORT_NUM);
                o_any = 1'b1;
            end
        end
        o_gnt[o_idx] = o_any;
    end
endmodule

// File: rtl/noc_switch_allocator.sv
// noc_switch_allocator: wormhole switch allocator, round-robin head arbitration with per-output locks.
// Optional sticky protocol-error flags are built when NOC_SA_ERR_CHECK_EN is defined.
module noc_switch_allocator
    import noc_params::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PORT_NUM-1:0] in_valid,
    input  flit_label_t         in_label [PORT_NUM],
    input  port_t               in_dest  [PORT_NUM],
    output logic [PORT_NUM-1:0] in_ready,
    input  logic [PORT_NUM-1:0] out_ready,
    output logic [PORT_NUM-1:0] out_valid,
    output port_t               xbar_sel [PORT_NUM],
    output logic [PORT_NUM-1:0] err
);
    sa_state_t           r_state [PORT_NUM];
    port_t               r_owner [PORT_NUM];
    port_t               r_ptr   [PORT_NUM];
    logic [PORT_NUM-1:0] w_locked_in, w_head, w_lk, w_any;
    logic [PORT_NUM-1:0] w_req [PORT_NUM];
    logic [PORT_NUM-1:0] w_gnt [PORT_NUM];
    port_t               w_win [PORT_NUM];
    port_t               w_cur [PORT_NUM];

    always_comb begin
        w_locked_in = '0;
        w_head      = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int o = 0; o < PORT_NUM; o++)
                w_locked_in[i] = w_locked_in[i] | ((r_state[o] == SA_LOCKED) && (r_owner[o] == port_t'(i)));
            w_head[i] = in_valid[i] && (in_label[i] == HEAD || in_label[i] == HEADTAIL)
                      && (in_dest[i] <= PORT_LAST) && !w_locked_in[i];
        end
        for (int o = 0; o < PORT_NUM; o++)
            for (int i = 0; i < PORT_NUM; i++)
                w_req[o][i] = w_head[i] && (in_dest[i] == port_t'(o));
    end

    for (genvar g = 0; g < PORT_NUM; g++) begin : g_arb
        noc_rr_arbiter u_arb (
            .i_req (w_req[g]),
            .i_ptr (r_ptr[g]),
            .o_gnt (w_gnt[g]),
            .o_idx (w_win[g]),
            .o_any (w_any[g])
        );
    end

    always_comb begin
        in_ready = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            w_lk[o]      = r_state[o] == SA_LOCKED;
            w_cur[o]     = w_lk[o] ? r_owner[o] : w_win[o];
            out_valid[o] = !rst && out_ready[o] && (w_lk[o]
                         ? in_valid[r_owner[o]] && (in_label[r_owner[o]] == BODY || in_label[r_owner[o]] == TAIL)
                         : w_any[o]);
            xbar_sel[o]  = out_valid[o] ? w_cur[o] : '0;
            for (int i = 0; i < PORT_NUM; i++)
                in_ready[i] = in_ready[i] | (out_valid[o] && (w_lk[o] ? r_owner[o] == port_t'(i) : w_gnt[o][i]));
        end
    end

    // Pointer moves only at packet end, so a multi-flit packet keeps its priority slot until TAIL.
    always_ff @(posedge clk) begin
        for (int o = 0; o < PORT_NUM; o++) begin
            if (rst) begin
                r_state[o] <= SA_IDLE;
                r_owner[o] <= '0;
                r_ptr[o]   <= '0;
            end else if (out_valid[o]) begin
                if (!w_lk[o] && in_label[w_cur[o]] == HEAD) begin
                    r_state[o] <= SA_LOCKED;
                    r_owner[o] <= w_win[o];
                end else if (in_label[w_cur[o]] == HEADTAIL || in_label[w_cur[o]] == TAIL) begin
                    r_state[o] <= SA_IDLE;
                    r_ptr[o]   <= next_port(w_cur[o]);
                end
            end
        end
    end

`ifdef NOC_SA_ERR_CHECK_EN
    logic [PORT_NUM-1:0] r_err, w_bad;

    always_comb begin
        w_bad = '0;
        for (int i = 0; i < PORT_NUM; i++)
            w_bad[i] = in_valid[i] && ((in_label[i] == HEAD || in_label[i] == HEADTAIL)
                     ? (w_locked_in[i] || in_dest[i] > PORT_LAST) : !w_locked_in[i]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= '0;
        else
            r_err <= r_err | w_bad;
    end

    assign err = r_err;
`else
    assign err = '0;
`endif
endmodule
